// File: rtl/rf_bist_pkg.sv
// Shared types and constants for the register-file BIST controller.
package rf_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDone
    } state_e;

    localparam int unsigned RF_DEPTH = 32;
    localparam int unsigned RF_AW    = 5;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // An all-zero Galois LFSR never leaves zero, so substitute a legal seed.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/rf_bist_lfsr.sv
// 32-bit right-shifting Galois LFSR; load has priority over step.
module rf_bist_lfsr
    import rf_bist_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        step_i,
    output logic [31:0] q_o
);

    logic [31:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_POLY) : (state_q >> 1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= 32'h1;
        end else begin
            state_q <= state_d;
        end
    end

    assign q_o = state_q;

endmodule

// File: rtl/rf_bist.sv
// Register-file BIST: fills all registers with LFSR data, then reads both ports back
// and reports pass/fail, error count and the first failing address.
module rf_bist
    import rf_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_1234
) (
    input  logic               clk_i,
    input  logic               reset_n,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [RF_AW:0]     err_cnt_o,
    output logic [RF_AW-1:0]   fail_addr_o,
    output logic [RF_AW-1:0]   a1_o,
    output logic [RF_AW-1:0]   a2_o,
    output logic [RF_AW-1:0]   a3_o,
    output logic [31:0]        wd3_o,
    output logic               we3_o,
    input  logic [31:0]        rd1_i,
    input  logic [31:0]        rd2_i
);

    localparam logic [RF_AW-1:0] LastAddr = RF_AW'(RF_DEPTH - 1);

    state_e           state_q, state_d;
    logic [RF_AW-1:0] addr_q, addr_d;
    logic [RF_AW:0]   err_cnt_q, err_cnt_d;
    logic [RF_AW-1:0] fail_addr_q, fail_addr_d;
    logic             pass_q, pass_d;

    logic             lfsr_load, lfsr_step;
    logic [31:0]      lfsr_q;
    logic [31:0]      expected;
    logic             mismatch;

    rf_bist_lfsr u_lfsr (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .load_i  (lfsr_load),
        .seed_i  (lfsr_seed(SEED)),
        .step_i  (lfsr_step),
        .q_o     (lfsr_q)
    );

    // x0 is hardwired to zero in rf, so the write to it must read back as 0.
    assign expected = (addr_q == '0) ? 32'h0 : lfsr_q;
    assign mismatch = (rd1_i != expected) || (rd2_i != expected);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        pass_d      = pass_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        a1_o        = '0;
        a2_o        = '0;
        a3_o        = '0;
        wd3_o       = 32'h0;
        we3_o       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StWrite;
                    addr_d      = '0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    pass_d      = 1'b0;
                    lfsr_load   = 1'b1;
                end
            end
            StWrite: begin
                busy_o = 1'b1;
                a3_o   = addr_q;
                wd3_o  = lfsr_q;
                we3_o  = 1'b1;
                addr_d = addr_q + 1'b1;
                if (addr_q == LastAddr) begin
                    // Replay the same sequence for the read-back pass.
                    state_d   = StRead;
                    lfsr_load = 1'b1;
                end else begin
                    lfsr_step = 1'b1;
                end
            end
            StRead: begin
                busy_o    = 1'b1;
                a1_o      = addr_q;
                a2_o      = addr_q;
                lfsr_step = 1'b1;
                addr_d    = addr_q + 1'b1;
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                    if (err_cnt_q == '0) begin
                        fail_addr_d = addr_q;
                    end
                end
                if (addr_q == LastAddr) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                pass_d  = (err_cnt_q == '0);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            pass_q      <= pass_d;
        end
    end

    assign pass_o      = pass_q;
    assign err_cnt_o   = err_cnt_q;
    assign fail_addr_o = fail_addr_q;

endmodule
